muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multi-cycle sequencer for the RV32 M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the single-cycle ALU in the execute stage.
- Accepts one operation through a valid/ready handshake and runs a radix-2 shift-add (multiply) or restoring shift-subtract (divide) loop for 32 iterations.
- Presents the 32-bit result through a valid/ready handshake held until consumed.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; only 32 is supported, and the counter width is derived as $clog2(XLEN)+1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  high only in IDLE.
- `op`  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  XLEN  rs1 operand (multiplicand / dividend).
- `b`  in  XLEN  rs2 operand (multiplier / divisor).
- `flush`  in  1  abort the in-flight operation (pipeline kill).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  XLEN  operation result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: `in_ready`=1. On `in_valid`, latch `op`, `a`, `b` and go to PREP.
- PREP (1 cycle):
  - Record sign flags per op: signed a for MULH/MULHSU/DIV/REM; signed b for MULH/DIV/REM.
  - Convert signed negative operands to magnitude.
  - Clear the 64-bit accumulator; load the iteration counter with 32.
  - Record `div_zero` (b==0) and `ovf` (DIV/REM with a==0x80000000, b==0xFFFFFFFF).
- CALC (32 cycles, counter decrements 32→1, leaves CALC when it reaches 0):
  - Multiply: if the multiplier LSB is set, add the multiplicand into the upper 33 bits; then shift right 1.
  - Divide: shift {rem,quot} left 1; trial subtract the divisor from the 33-bit remainder; if non-negative, keep it and set quot LSB.
- FIX (1 cycle): select and sign-correct.
  - MUL returns the low 32 bits of the product, high ops the high 32 bits. Product negated if the sign flags differ.
  - Quotient negated if the sign flags differ; remainder takes the sign of the dividend.
  - `div_zero`: quotient 0xFFFFFFFF (both signed and unsigned); remainder = original `a`.
  - `ovf`: quotient 0x80000000; remainder 0.
- DONE: `out_valid`=1 and `result` is held stable. On `out_ready`, go to IDLE.
- `flush` in PREP/CALC/FIX/DONE: go to IDLE next cycle; no `out_valid` is produced. In IDLE, `flush` has priority over `in_valid` (request not accepted).
- All arithmetic uses unsigned magnitudes internally, with a 33-bit adder/subtractor to keep the carry/borrow.

## Timing
- Reset values:
  - State IDLE; `in_ready`=1, `out_valid`=0, `busy`=0.
  - `result`=0; counter=0; accumulator and latched operands cleared.
- Accept at edge T0 (in_valid&&in_ready). PREP at T1, CALC T2..T33, FIX T34, `out_valid` high from T35.
- Latency from accept to `out_valid` is fixed at 35 cycles for every op, including div-by-zero and overflow (no fast path).
- Throughput: the next accept is possible the cycle after the result handshake (IDLE), so the minimum issue interval is 36 cycles.
- Backpressure: while `out_ready`=0 in DONE, `result` and `out_valid` are held indefinitely; `in_ready` stays 0.
- Reset mid-operation: the next cycle is IDLE with reset values; the in-flight result is discarded.
- Flush and `out_ready` together in DONE: go to IDLE; the consumer must treat the result as not transferred.
- Outputs are registered or pure state decodes; no combinational path from inputs to outputs.

## Structure
- Shared package `muldiv_pkg`:
  - op localparams (OP_MUL..OP_REMU);
  - state encoding (S_IDLE..S_DONE, 3 bits);
  - constants INT_MIN=32'h80000000 and ALL_ONES=32'hFFFFFFFF.
- Sub-module `muldiv_step`: combinational, one iteration. Inputs: mode, 64-bit accumulator, 32-bit operand. Outputs: next accumulator.
- `muldiv_seq` holds the FSM, the counter, the sign/special-case flags and the FIX logic.

## Test plan
- MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB at T35. MULH 0x80000000×0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF (−1), b=0xFFFFFFFF (unsigned) -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. All at the fixed 35-cycle latency.
- Hold `out_ready`=0 for 5 cycles in DONE -> `result` stable, `in_ready`=0. Assert `in_valid` during CALC -> not accepted; accepted the cycle after the result handshake.
- `flush` at T10 (CALC) -> IDLE at T11 with no `out_valid`. `rst` at T20 -> all outputs at reset values. A following MUL 3×4 -> 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32 M-extension multi-cycle unit:
// funct3 op codes, FSM state encoding, step mode and operand-sign helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

    // rs1 is treated as signed by the high-product and signed divide ops.
    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply ({hi, multiplier} shifts right),
// restoring shift-subtract for divide ({rem, quot} shifts left).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mode_t               mode,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] diff;

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
        // The shifted remainder is 33 bits; since it is below 2*divisor, bit XLEN of
        // the difference is the borrow.
        diff     = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
        acc_next = acc;
        if (mode == MODE_MUL) begin
            if (acc[0])
                acc_next = {sum, acc[XLEN-1:1]};
            else
                acc_next = {1'b0, acc[2*XLEN-1:1]};
        end else begin
            if (diff[XLEN])
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            else
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32 M-extension sequencer: accept, prepare magnitudes, 32 radix-2
// iterations, sign/special-case fix-up, then hold the result until consumed.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    state_t              state, state_next;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q, b_q;
    logic [XLEN-1:0]     operand;
    logic [2*XLEN-1:0]   acc, acc_next;
    logic [CNT_W-1:0]    cnt;
    logic                neg_a, neg_b, div_zero, ovf;
    logic [XLEN-1:0]     result_q;

    logic                sa, sb;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quot_s, rem_s, fix_result;
    mode_t               mode;

    assign mode      = op_q[2] ? MODE_DIV : MODE_MUL;
    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign result    = result_q;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .mode     (mode),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    always_comb begin
        sa    = a_is_signed(op_q) && a_q[XLEN-1];
        sb    = b_is_signed(op_q) && b_q[XLEN-1];
        mag_a = sa ? (~a_q + 1'b1) : a_q;
        mag_b = sb ? (~b_q + 1'b1) : b_q;
    end

    // Fix-up: negate magnitudes back, then let divide special cases override.
    always_comb begin
        prod_s     = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
        quot_s     = (neg_a ^ neg_b) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem_s      = neg_a ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        fix_result = '0;
        case (op_q)
            OP_MUL:                         fix_result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fix_result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (div_zero)   fix_result = ALL_ONES;
                else if (ovf)   fix_result = INT_MIN;
                else            fix_result = quot_s;
            end
            default: begin
                if (div_zero)   fix_result = a_q;
                else if (ovf)   fix_result = '0;
                else            fix_result = rem_s;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (!flush && in_valid) state_next = S_PREP;
            S_PREP: state_next = flush ? S_IDLE : S_CALC;
            S_CALC: begin
                if (flush)                      state_next = S_IDLE;
                else if (cnt == CNT_W'(1))      state_next = S_FIX;
            end
            S_FIX:  state_next = flush ? S_IDLE : S_DONE;
            S_DONE: if (flush || out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: the datapath registers are few and flop-based, so all of them take the reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            operand  <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                    end
                end
                S_PREP: begin
                    neg_a    <= sa;
                    neg_b    <= sb;
                    div_zero <= (b_q == '0);
                    ovf      <= ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                                (a_q == INT_MIN) && (b_q == ALL_ONES);
                    cnt      <= CNT_W'(XLEN);
                    // Low half preloads the multiplier (multiply) or dividend (divide).
                    if (op_q[2]) begin
                        acc     <= {{XLEN{1'b0}}, mag_a};
                        operand <= mag_b;
                    end else begin
                        acc     <= {{XLEN{1'b0}}, mag_b};
                        operand <= mag_a;
                    end
                end
                S_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                end
                S_FIX:   result_q <= fix_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed results, fixed 35-cycle latency,
// backpressure, busy-time requests, flush and mid-operation reset.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, ending on the following falling edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Issue one op, check it is absent at T34 and present at T35, then consume it.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] expected);
        op = o; a = x; b = y; in_valid = 1'b1;
        check({tag, "_accept"}, 32'(in_ready), 32'd1);
        cyc(1);
        in_valid = 1'b0;
        cyc(33);
        check({tag, "_early"}, 32'(out_valid), 32'd0);
        cyc(1);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, result, expected);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        check({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; a = '0; b = '0;
        flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        cyc(2);
        check_idle("reset");
        check("reset_result", result, 32'h0);
        rst = 1'b0;
        cyc(1);

        run_op("mul",     3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
        run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
        run_op("divu",    3'b101, 32'd100,      32'd7,        32'd14);
        run_op("remu",    3'b111, 32'd100,      32'd7,        32'd2);
        run_op("div_z",   3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF);
        run_op("divu_z",  3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF);
        run_op("rem_z",   3'b110, 32'd5,        32'd0,        32'd5);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Backpressure plus a request raised while busy.
        op = 3'b101; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        cyc(5);
        op = 3'b111; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        cyc(1);
        check("calc_in_ready", 32'(in_ready), 32'd0);
        check("calc_busy",     32'(busy),     32'd1);
        cyc(27);
        check("bp_early", 32'(out_valid), 32'd0);
        cyc(1);
        check("bp_valid",  32'(out_valid), 32'd1);
        check("bp_result", result, 32'd14);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("bp_hold_result",   result,              32'd14);
            check("bp_hold_valid",    32'(out_valid),      32'd1);
            check("bp_hold_in_ready", 32'(in_ready),       32'd0);
        end
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        check("reaccept_idle", 32'(in_ready), 32'd1);
        cyc(1);
        in_valid = 1'b0;
        check("reaccept_busy", 32'(busy), 32'd1);
        cyc(33);
        check("reaccept_early", 32'(out_valid), 32'd0);
        cyc(1);
        check("reaccept_valid",  32'(out_valid), 32'd1);
        check("reaccept_result", result, 32'd2);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;

        // Flush beats a request in IDLE.
        op = 3'b000; a = 32'd3; b = 32'd5; in_valid = 1'b1; flush = 1'b1;
        cyc(1);
        in_valid = 1'b0; flush = 1'b0;
        check_idle("flush_idle");

        // Flush during CALC at T10.
        in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        cyc(9);
        check("flush_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        check_idle("flush_calc");
        seen = 0;
        repeat (40) begin
            cyc(1);
            if (out_valid) seen = 1;
        end
        check("flush_no_valid", 32'(seen), 32'd0);

        // Reset at T20 of a divide.
        op = 3'b100; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        cyc(19);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_idle("mid_reset");
        check("mid_reset_result", result, 32'h0);
        seen = 0;
        repeat (40) begin
            cyc(1);
            if (out_valid) seen = 1;
        end
        check("mid_reset_no_valid", 32'(seen), 32'd0);

        run_op("mul_after", 3'b000, 32'd3, 32'd4, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
